// File: rtl/awg_sweep_controller.sv
// Frequency sweep sequencer for the waveform generator. It steps the tone from
// f_start to f_stop, holds each tone for the programmed dwell and repeats for N
// passes. The generator is held in reset whenever the sweep is not dwelling.
module awg_sweep_controller #(
  parameter int FREQ_W  = 16,
  parameter int AMP_W   = 10,
  parameter int DWELL_W = 24,
  parameter int REP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_type,
  input  logic [FREQ_W-1:0]  cfg_f_start,
  input  logic [FREQ_W-1:0]  cfg_f_stop,
  input  logic [FREQ_W-1:0]  cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [AMP_W-1:0]   cfg_offset,
  input  logic [REP_W-1:0]   cfg_repeat,
  output logic [1:0]         waveform_type,
  output logic [FREQ_W-1:0]  frequency,
  output logic [AMP_W-1:0]   amplitude,
  output logic [AMP_W-1:0]   dc_offset,
  output logic               gen_rst,
  output logic               busy,
  output logic               done,
  output logic               step_strobe
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t state, state_next;

  logic [FREQ_W-1:0]  f_start_q, f_stop_q, f_step_q;
  logic [DWELL_W-1:0] dwell_q, dwell_eff, dwell_cnt;
  logic [REP_W-1:0]   repeat_q, pass_cnt;
  logic [REP_W:0]     pass_next;
  logic [FREQ_W:0]    up_sum, down_diff;
  logic [FREQ_W-1:0]  next_tone;
  logic               sweep_up, dwell_last, tone_advance, pass_again;

  // Sweep arithmetic: next tone is computed one bit wider so the clamp to
  // f_stop also catches overflow above the top and underflow below zero.
  always_comb begin
    dwell_eff    = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    dwell_last   = (dwell_cnt == DWELL_W'(1));
    tone_advance = (frequency != f_stop_q) && (f_step_q != '0);
    pass_next    = {1'b0, pass_cnt} + (REP_W+1)'(1);
    pass_again   = (repeat_q == '0) || (pass_next < {1'b0, repeat_q});
    sweep_up     = (f_stop_q >= f_start_q);
    up_sum       = {1'b0, frequency} + {1'b0, f_step_q};
    down_diff    = {1'b0, frequency} - {1'b0, f_step_q};
    next_tone    = f_stop_q;
    if (sweep_up) begin
      if (up_sum < {1'b0, f_stop_q}) next_tone = up_sum[FREQ_W-1:0];
    end else begin
      if (!down_diff[FREQ_W] && (down_diff > {1'b0, f_stop_q}))
        next_tone = down_diff[FREQ_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = DWELL;
      DWELL:   if (dwell_last && !tone_advance && !pass_again) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Shadow config, tone/dwell/pass counters and the step strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_start_q     <= '0;
      f_stop_q      <= '0;
      f_step_q      <= '0;
      dwell_q       <= '0;
      repeat_q      <= '0;
      dwell_cnt     <= '0;
      pass_cnt      <= '0;
      waveform_type <= '0;
      frequency     <= '0;
      amplitude     <= '0;
      dc_offset     <= '0;
      step_strobe   <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            f_start_q     <= cfg_f_start;
            f_stop_q      <= cfg_f_stop;
            f_step_q      <= cfg_f_step;
            dwell_q       <= cfg_dwell;
            repeat_q      <= cfg_repeat;
            pass_cnt      <= '0;
            waveform_type <= cfg_type;
            frequency     <= cfg_f_start;
            amplitude     <= cfg_amp;
            dc_offset     <= cfg_offset;
          end
        end
        LOAD: dwell_cnt <= dwell_eff;
        DWELL: begin
          if (!abort) begin
            if (dwell_last) begin
              dwell_cnt <= dwell_eff;
              if (tone_advance) begin
                frequency   <= next_tone;
                step_strobe <= 1'b1;
              end else begin
                pass_cnt <= pass_next[REP_W-1:0];
                if (pass_again) begin
                  frequency   <= f_start_q;
                  step_strobe <= 1'b1;
                end
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gen_rst = (state != DWELL);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_awg_sweep_controller.sv
// Bench for awg_sweep_controller: directed vector table, hand-written abort and
// reset sequences, and randomized sweeps against a tone-list reference model.
module tb_awg_sweep_controller;

  logic        clk, rst_n, start, abort;
  logic [1:0]  cfg_type;
  logic [15:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [23:0] cfg_dwell;
  logic [9:0]  cfg_amp, cfg_offset;
  logic [7:0]  cfg_repeat;
  logic [1:0]  waveform_type;
  logic [15:0] frequency;
  logic [9:0]  amplitude, dc_offset;
  logic        gen_rst, busy, done, step_strobe;

  awg_sweep_controller #(.FREQ_W(16), .AMP_W(10), .DWELL_W(24), .REP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_type(cfg_type), .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop),
    .cfg_f_step(cfg_f_step), .cfg_dwell(cfg_dwell), .cfg_amp(cfg_amp),
    .cfg_offset(cfg_offset), .cfg_repeat(cfg_repeat),
    .waveform_type(waveform_type), .frequency(frequency), .amplitude(amplitude),
    .dc_offset(dc_offset), .gen_rst(gen_rst), .busy(busy), .done(done),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wtype;
    logic [15:0] fs, fe, step;
    logic [23:0] dwell;
    logic [7:0]  rep;
    logic [9:0]  amp, off;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int   exp_done;
    int   exp_strobes;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [41:0] exp_q[$];
  logic [41:0] dut_vec;
  localparam logic [41:0] RESET_VEC = {4'b0100, 38'd0};

  assign dut_vec = {busy, gen_rst, done, step_strobe, waveform_type, amplitude, dc_offset, frequency};

  task automatic check(input string name, input logic [41:0] got, input logic [41:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (busy,gen_rst,done,strobe,type,amp,off,freq) t=%0t",
               name, got, expv, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic logic [41:0] pack(input logic b, input logic g, input logic d,
                                       input logic s, input cfg_t c, input int f);
    return {b, g, d, s, c.wtype, c.amp, c.off, 16'(f)};
  endfunction

  // Reference: list the tones of one pass with plain integer arithmetic, then
  // expand into the expected per-cycle trace starting at the LOAD cycle.
  task automatic build_model(input cfg_t c);
    int tones[$];
    int t, fs, fe, st, d, p;
    exp_q.delete();
    fs = int'(c.fs); fe = int'(c.fe); st = int'(c.step);
    t = fs;
    tones.push_back(t);
    while (t != fe && st != 0) begin
      if (fe >= fs) t = (t + st > fe) ? fe : t + st;
      else          t = (t - st < fe) ? fe : t - st;
      tones.push_back(t);
    end
    d = (c.dwell == 0) ? 1 : int'(c.dwell);
    p = (c.rep == 0) ? 3 : int'(c.rep);
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, c, fs));
    for (int pi = 0; pi < p; pi++)
      for (int ti = 0; ti < tones.size(); ti++)
        for (int k = 0; k < d; k++)
          exp_q.push_back(pack(1'b1, 1'b0, 1'b0, (k == 0) && !(pi == 0 && ti == 0), c, tones[ti]));
    if (c.rep != 0) exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, c, tones[tones.size()-1]));
  endtask

  task automatic scramble();
    cfg_type    = 2'($urandom);
    cfg_f_start = 16'($urandom);
    cfg_f_stop  = 16'($urandom);
    cfg_f_step  = 16'($urandom);
    cfg_dwell   = 24'($urandom_range(0, 5));
    cfg_amp     = 10'($urandom);
    cfg_offset  = 10'($urandom);
    cfg_repeat  = 8'($urandom_range(0, 4));
    start       = 1'($urandom);
  endtask

  // One sweep: start in cycle 0, compare each cycle against the model; abort_at>0
  // asserts abort in that cycle, abort_at<0 picks a random abort cycle.
  task automatic run(input cfg_t c, input int abort_at, output int done_cyc, output int strobes);
    int n;
    logic [41:0] idle_v;
    build_model(c);
    if (abort_at < 0) abort_at = $urandom_range(1, exp_q.size());
    done_cyc = -1;
    strobes  = 0;
    @(negedge clk);
    cfg_type = c.wtype; cfg_f_start = c.fs; cfg_f_stop = c.fe; cfg_f_step = c.step;
    cfg_dwell = c.dwell; cfg_amp = c.amp; cfg_offset = c.off; cfg_repeat = c.rep;
    start = 1'b1;
    @(negedge clk);
    scramble();
    n = (abort_at > 0) ? abort_at : exp_q.size();
    for (int cyc = 1; cyc <= n; cyc++) begin
      check("trace", dut_vec, exp_q[cyc-1]);
      if (step_strobe) strobes++;
      if (done) done_cyc = cyc;
      scramble();
      if (cyc == abort_at) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    idle_v = {4'b0100, exp_q[n-1][37:0]};
    check("idle_after", dut_vec, idle_v);
    start = 1'b0;
  endtask

  vec_t tbl[7];
  cfg_t c;
  int dc, st;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_type = '0; cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
    cfg_dwell = '0; cfg_amp = '0; cfg_offset = '0; cfg_repeat = '0;

    tbl[0] = '{c: '{2'd1, 16'd1000,  16'd1300,  16'd100,  24'd4, 8'd1, 10'd500, 10'd20}, exp_done: 18, exp_strobes: 3};
    tbl[1] = '{c: '{2'd2, 16'd1000,  16'd1250,  16'd100,  24'd2, 8'd1, 10'd300, 10'd5},  exp_done: 10, exp_strobes: 3};
    tbl[2] = '{c: '{2'd3, 16'd500,   16'd300,   16'd100,  24'd1, 8'd2, 10'd1,   10'd2},  exp_done: 8,  exp_strobes: 5};
    tbl[3] = '{c: '{2'd0, 16'd1000,  16'd1000,  16'd0,    24'd0, 8'd3, 10'd77,  10'd9},  exp_done: 5,  exp_strobes: 2};
    tbl[4] = '{c: '{2'd1, 16'd1000,  16'd2000,  16'd0,    24'd3, 8'd1, 10'd10,  10'd11}, exp_done: 5,  exp_strobes: 0};
    tbl[5] = '{c: '{2'd2, 16'd65000, 16'd65535, 16'd1000, 24'd1, 8'd1, 10'd1023,10'd0},  exp_done: 4,  exp_strobes: 1};
    tbl[6] = '{c: '{2'd3, 16'd300,   16'd0,     16'd200,  24'd1, 8'd1, 10'd4,   10'd3},  exp_done: 5,  exp_strobes: 2};

    #12;
    check("reset_state", dut_vec, RESET_VEC);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", dut_vec, RESET_VEC);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].c, 0, dc, st);
      check_int($sformatf("done_cycle[%0d]", i), dc, tbl[i].exp_done);
      check_int($sformatf("strobes[%0d]", i), st, tbl[i].exp_strobes);
    end

    // Abort at cycle 7 of the up sweep, then confirm no late done and a clean restart.
    run(tbl[0].c, 7, dc, st);
    check_int("abort_no_done", dc, -1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_int("abort_quiet", {busy, done, gen_rst}, 1);
    end
    run(tbl[0].c, 0, dc, st);
    check_int("restart_done_cycle", dc, 18);

    // Start while busy is ignored; rst_n mid-dwell clears outputs asynchronously.
    @(negedge clk);
    cfg_type = 2'd1; cfg_f_start = 16'd1000; cfg_f_stop = 16'd1300; cfg_f_step = 16'd100;
    cfg_dwell = 24'd4; cfg_amp = 10'd500; cfg_offset = 10'd20; cfg_repeat = 8'd1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 4) begin
        cfg_f_start = 16'd5; cfg_f_stop = 16'd7; start = 1'b1;
      end
      if (cyc == 6) check_int("busy_start_ignored", {busy, frequency}, {1'b1, 16'd1100});
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec, RESET_VEC);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_idle", dut_vec, RESET_VEC);
    run(tbl[2].c, 0, dc, st);
    check_int("post_reset_done_cycle", dc, 8);

    // Randomized sweeps, including continuous (repeat 0) runs ended by abort.
    for (int i = 0; i < 30; i++) begin
      c.wtype = 2'($urandom);
      c.amp   = 10'($urandom);
      c.off   = 10'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        c.fs = 16'(65535 - $urandom_range(0, 3000));
        c.fe = 16'(65535 - $urandom_range(0, 3000));
      end else begin
        c.fs = 16'($urandom_range(0, 3000));
        c.fe = 16'($urandom_range(0, 3000));
      end
      c.step  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(80, 900));
      c.dwell = 24'($urandom_range(0, 3));
      c.rep   = 8'($urandom_range(0, 3));
      run(c, (c.rep == 0 || $urandom_range(0, 3) == 0) ? -1 : 0, dc, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
